// File: rtl/tankb_video_timing.sv
// -----------------------------------------------------------------------------
// tankb_video_timing
//
// Raster timing generator for the discrete-logic video path. Produces the pixel
// and line counters, syncs, blanking, the 74LS166 shift/load strobe and the
// line / vblank event pulses. Everything advances on clk edges qualified by
// the pixel clock enable ce_pix.
//
// Every output is registered and decoded from the same next-state counter
// values that are loaded into hcnt/vcnt. All outputs therefore change on the
// same edge as the counters they describe, and none of them skews.
//
// Optional feature: define TANKB_FLIP_EN to add the `flip` input. Its value is
// latched at frame start (the edge producing hcnt=0, vcnt=0). While the latch
// is set, hpos/vpos are the bitwise inverse of the counters.
//
// Ports
//   clk         in   master clock
//   reset       in   asynchronous, active-high reset
//   ce_pix      in   pixel clock enable
//   flip        in   screen flip request (TANKB_FLIP_EN builds only)
//   hcnt[8:0]   out  current pixel, 0..H_TOTAL-1
//   vcnt[8:0]   out  current line,  0..V_TOTAL-1
//   hpos[7:0]   out  pixel address to the video RAM/ROM path
//   vpos[7:0]   out  line address to the video RAM/ROM path
//   hsync_n     out  active-low horizontal sync
//   vsync_n     out  active-low vertical sync
//   hblank      out  high outside the active pixels
//   vblank      out  high outside the active lines
//   load_n      out  active-low 74LS166 shift/load strobe
//   line_start  out  one-clk pulse on the edge producing hcnt=0
//   vbl_start   out  one-clk pulse on the edge producing hcnt=0, vcnt=V_ACTIVE
// -----------------------------------------------------------------------------
module tankb_video_timing #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 304,
  parameter int HS_WIDTH = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
`ifdef TANKB_FLIP_EN
  input  logic       flip,
`endif
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic [7:0] hpos,
  output logic [7:0] vpos,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hblank,
  output logic       vblank,
  output logic       load_n,
  output logic       line_start,
  output logic       vbl_start
);

  // A sync window that runs past the total is cut off there. The counter never
  // reaches those values, so no wrap-around handling is needed.
  function automatic logic in_window(input int val, input int start, input int width);
    return (val >= start) && (val < start + width);
  endfunction

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       frame_start;
  logic       flip_nxt;

  // Next counter position, used only when ce_pix is high.
  always_comb begin
    // NOTE: assign every combinational output a default first, so that no
    // path through the block leaves a signal unassigned (which infers a latch).
    h_nxt = hcnt + 9'd1;
    v_nxt = vcnt;
    if (hcnt == 9'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (vcnt == 9'(V_TOTAL - 1)) ? '0 : vcnt + 9'd1;
    end
  end

  assign frame_start = (h_nxt == '0) && (v_nxt == '0);

`ifdef TANKB_FLIP_EN
  logic flip_q;

  // The new flip value already applies to the position 0,0 that it is
  // latched with.
  assign flip_nxt = frame_start ? flip : flip_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flip_q <= 1'b0;
    end else if (ce_pix) begin
      flip_q <= flip_nxt;
    end
  end
`else
  assign flip_nxt = 1'b0;
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      hpos       <= '0;
      vpos       <= '0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      hblank     <= 1'b0;
      vblank     <= 1'b0;
      load_n     <= 1'b1;
      line_start <= 1'b0;
      vbl_start  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge, whatever the statement
      // order.
      // The pulses drop on the next clk edge even when ce_pix is low.
      line_start <= 1'b0;
      vbl_start  <= 1'b0;
      if (ce_pix) begin
        hcnt       <= h_nxt;
        vcnt       <= v_nxt;
        hpos       <= flip_nxt ? ~h_nxt[7:0] : h_nxt[7:0];
        vpos       <= flip_nxt ? ~v_nxt[7:0] : v_nxt[7:0];
        hblank     <= int'(h_nxt) >= H_ACTIVE;
        vblank     <= int'(v_nxt) >= V_ACTIVE;
        hsync_n    <= ~in_window(int'(h_nxt), HS_START, HS_WIDTH);
        // v_nxt differs from vcnt only at the line wrap, so vsync_n can only
        // change together with the hcnt wrap.
        vsync_n    <= ~in_window(int'(v_nxt), VS_START, VS_WIDTH);
        // The strobe sits on the last pixel of each 8-pixel group. The
        // shifter therefore loads on the edge that takes hcnt to a multiple
        // of 8.
        load_n     <= ~((h_nxt[2:0] == 3'd7) && (int'(h_nxt) < H_ACTIVE));
        line_start <= (h_nxt == '0);
        vbl_start  <= (h_nxt == '0) && (int'(v_nxt) == V_ACTIVE);
      end
    end
  end

endmodule

// File: tb/tb_tankb_video_timing.sv
`timescale 1ns/1ps
module tb_tankb_video_timing;

  // Scaled raster for the frame-level tests. It keeps whole frames short and
  // still runs hcnt past 255. Both sync windows run past the totals, so they
  // are truncated.
  localparam int HT = 280, HA = 256, HS = 264, HW = 24;
  localparam int VT = 10,  VA = 6,   VS = 8,   VW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic flip;

  // Default-parameter instance (d_*), used for the line-level vector table.
  logic       rst_d, ce_d;
  logic [8:0] d_hcnt, d_vcnt;
  logic [7:0] d_hpos, d_vpos;
  logic       d_hsync_n, d_vsync_n, d_hblank, d_vblank, d_load_n, d_line_start, d_vbl_start;

  // Scaled instance (s_*), checked against the reference model.
  logic       rst_s, ce_s;
  logic [8:0] s_hcnt, s_vcnt;
  logic [7:0] s_hpos, s_vpos;
  logic       s_hsync_n, s_vsync_n, s_hblank, s_vblank, s_load_n, s_line_start, s_vbl_start;

  tankb_video_timing u_dut_def (
    .clk(clk), .reset(rst_d), .ce_pix(ce_d),
`ifdef TANKB_FLIP_EN
    .flip(flip),
`endif
    .hcnt(d_hcnt), .vcnt(d_vcnt), .hpos(d_hpos), .vpos(d_vpos),
    .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .hblank(d_hblank), .vblank(d_vblank),
    .load_n(d_load_n), .line_start(d_line_start), .vbl_start(d_vbl_start)
  );

  tankb_video_timing #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HS), .HS_WIDTH(HW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VS), .VS_WIDTH(VW)
  ) u_dut_s (
    .clk(clk), .reset(rst_s), .ce_pix(ce_s),
`ifdef TANKB_FLIP_EN
    .flip(flip),
`endif
    .hcnt(s_hcnt), .vcnt(s_vcnt), .hpos(s_hpos), .vpos(s_vpos),
    .hsync_n(s_hsync_n), .vsync_n(s_vsync_n), .hblank(s_hblank), .vblank(s_vblank),
    .load_n(s_load_n), .line_start(s_line_start), .vbl_start(s_vbl_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the raster position is the number of ce_pix edges since
  // reset, taken modulo the frame length. Outputs come from the window rules.
  // ---------------------------------------------------------------------------
  int p, m_h, m_v;
  bit m_ls, m_vb, m_flip;

  function automatic void model_reset();
    p = 0; m_h = 0; m_v = 0; m_ls = 0; m_vb = 0; m_flip = 0;
  endfunction

  function automatic void model_step(input bit ce, input bit fl);
    m_ls = 0;
    m_vb = 0;
    if (ce) begin
      p   = (p + 1) % (HT * VT);
      m_h = p % HT;
      m_v = p / HT;
      m_ls = (m_h == 0);
      m_vb = (m_h == 0) && (m_v == VA);
`ifdef TANKB_FLIP_EN
      if (p == 0) m_flip = fl;
`endif
    end
  endfunction

  task automatic compare_all();
    logic [7:0] eh, ev;
    eh = 8'(m_h);
    ev = 8'(m_v);
    if (m_flip) begin
      eh = ~eh;
      ev = ~ev;
    end
    check("hcnt", s_hcnt, m_h);
    check("vcnt", s_vcnt, m_v);
    check("hpos", s_hpos, eh);
    check("vpos", s_vpos, ev);
    check("hsync_n", s_hsync_n, (m_h >= HS && m_h < HS + HW) ? 0 : 1);
    check("vsync_n", s_vsync_n, (m_v >= VS && m_v < VS + VW) ? 0 : 1);
    check("hblank", s_hblank, (m_h >= HA) ? 1 : 0);
    check("vblank", s_vblank, (m_v >= VA) ? 1 : 0);
    check("load_n", s_load_n, (m_h % 8 == 7 && m_h < HA) ? 0 : 1);
    check("line_start", s_line_start, m_ls);
    check("vbl_start", s_vbl_start, m_vb);
  endtask

  // Called at a negedge. Drives ce, clocks once, then compares on the negedge.
  task automatic step_s(input bit ce);
    ce_s = ce;
    @(posedge clk);
    model_step(ce, flip);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until(input int h, input int v, input int budget);
    int n = 0;
    while (!(m_h == h && m_v == v) && n < budget) begin
      step_s(1'b1);
      n++;
    end
    check("wait_target_hcnt", s_hcnt, h);
    check("wait_target_vcnt", s_vcnt, v);
  endtask

  // ---------------------------------------------------------------------------
  // Line-level vectors for the default raster: {edges since release, outputs}
  // ---------------------------------------------------------------------------
  typedef struct {
    int k;
    int hcnt;
    int vcnt;
    bit hsync_n;
    bit hblank;
    bit load_n;
    bit line_start;
    int hpos;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int kd, nload, nls, nvb, last_ls;

    tbl[0]  = '{0,   0,   0, 1, 0, 1, 0, 0};
    tbl[1]  = '{1,   1,   0, 1, 0, 1, 0, 1};
    tbl[2]  = '{7,   7,   0, 1, 0, 0, 0, 7};
    tbl[3]  = '{8,   8,   0, 1, 0, 1, 0, 8};
    tbl[4]  = '{255, 255, 0, 1, 0, 0, 0, 255};
    tbl[5]  = '{256, 256, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{263, 263, 0, 1, 1, 1, 0, 7};
    tbl[7]  = '{303, 303, 0, 1, 1, 1, 0, 47};
    tbl[8]  = '{304, 304, 0, 0, 1, 1, 0, 48};
    tbl[9]  = '{335, 335, 0, 0, 1, 1, 0, 79};
    tbl[10] = '{336, 336, 0, 1, 1, 1, 0, 80};
    tbl[11] = '{383, 383, 0, 1, 1, 1, 0, 127};
    tbl[12] = '{384, 0,   1, 1, 0, 1, 1, 0};
    tbl[13] = '{385, 1,   1, 1, 0, 1, 0, 1};
    tbl[14] = '{391, 7,   1, 1, 0, 0, 0, 7};
    tbl[15] = '{767, 383, 1, 1, 1, 1, 0, 127};

    flip  = 1'b0;
    ce_d  = 1'b0;
    ce_s  = 1'b0;
    rst_d = 1'b0;
    rst_s = 1'b0;
    #1;
    rst_d = 1'b1;
    rst_s = 1'b1;
    #1;
    // Reset applied with no clock edge yet.
    model_reset();
    compare_all();
    check("def_reset_hsync_n", d_hsync_n, 1);
    check("def_reset_vsync_n", d_vsync_n, 1);
    check("def_reset_load_n", d_load_n, 1);

    // ---- default raster, first two lines, table driven ----
    @(negedge clk);
    rst_d = 1'b0;
    ce_d  = 1'b1;
    kd = 0;
    nload = 0;
    for (int i = 0; i < NV; i++) begin
      while (kd < tbl[i].k) begin
        @(posedge clk);
        @(negedge clk);
        kd++;
        if (kd < 384 && d_load_n === 1'b0) nload++;
      end
      check("vec_hcnt", d_hcnt, tbl[i].hcnt);
      check("vec_vcnt", d_vcnt, tbl[i].vcnt);
      check("vec_hsync_n", d_hsync_n, tbl[i].hsync_n);
      check("vec_hblank", d_hblank, tbl[i].hblank);
      check("vec_load_n", d_load_n, tbl[i].load_n);
      check("vec_line_start", d_line_start, tbl[i].line_start);
      check("vec_hpos", d_hpos, tbl[i].hpos);
      check("vec_vblank", d_vblank, 0);
      check("vec_vsync_n", d_vsync_n, 1);
      check("vec_vbl_start", d_vbl_start, 0);
    end
    check("load_strobes_per_line", nload, 32);

    // ---- scaled raster: free-running count over two frames ----
    rst_s = 1'b0;
    compare_all();
    nls = 0;
    nvb = 0;
    for (int i = 1; i <= 2 * HT * VT; i++) begin
      step_s(1'b1);
      if (i <= HT * VT) begin
        if (s_line_start === 1'b1) nls++;
        if (s_vbl_start === 1'b1) nvb++;
      end
    end
    check("line_starts_per_frame", nls, VT);
    check("vbl_starts_per_frame", nvb, 1);

    // ---- ce_pix on every second clk: periods double ----
    last_ls = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step_s(i % 2 == 0);
      if (s_line_start === 1'b1) begin
        if (last_ls >= 0) check("line_period_half_ce", i - last_ls, 2 * HT);
        last_ls = i;
      end
    end

    // ---- randomized ce_pix and flip ----
    for (int i = 0; i < 12000; i++) begin
      flip = 1'($urandom_range(0, 1));
      step_s(1'($urandom_range(0, 1)));
    end
    flip = 1'b0;
    // Finish the frame, so that the flip latch is known clear again.
    run_until(0, 0, 3 * HT * VT);

    // ---- asynchronous reset mid-frame, inside both sync windows ----
    run_until(270, 8, 2 * HT * VT);
    #2;
    rst_s = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst_s = 1'b0;
    step_s(1'b1);
    check("no_line_start_after_release", s_line_start, 0);
    check("no_vbl_start_after_release", s_vbl_start, 0);
    check("hcnt_after_release", s_hcnt, 1);

`ifdef TANKB_FLIP_EN
    // ---- flip takes effect only at the next frame start ----
    run_until(0, 3, 2 * HT * VT);
    flip = 1'b1;
    run_until(5, 3, HT);
    check("flip_pending_hpos", s_hpos, 8'd5);
    check("flip_pending_vpos", s_vpos, 8'd3);
    run_until(5, 2, 2 * HT * VT);
    check("flip_hpos", s_hpos, 8'hFA);
    check("flip_vpos", s_vpos, 8'hFD);
    flip = 1'b0;
    run_until(0, 5, 2 * HT * VT);
    check("flip_held_midframe_hpos", s_hpos, 8'hFF);
    run_until(1, 0, 2 * HT * VT);
    check("unflip_hpos", s_hpos, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
